// File: rtl/gemm_store_pkg.sv
// Shared types, sizes and helper functions for the GEMM result store engine.
package gemm_store_pkg;

  localparam int LANES      = 4;
  localparam int ELEM_W     = 32;
  localparam int NUM_BUF    = 4;
  localparam int SIZE_W     = 5;
  localparam int ADDR_W     = 32;

  localparam int BEAT_W     = LANES * ELEM_W;
  localparam int STRB_W     = BEAT_W / 8;
  localparam int BEAT_BYTES = STRB_W;
  localparam int ELEM_BYTES = ELEM_W / 8;
  localparam int BIDX_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int CNT_W      = $clog2(NUM_BUF + 1);
  localparam int CFG_W      = SIZE_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ISSUE,
    GAP,
    FIN
  } state_t;

  // Unclamped beat count per row: ceil(nsize / LANES).
  function automatic logic [CFG_W-1:0] beats_of(input logic [SIZE_W-1:0] nsize);
    return (CFG_W'(nsize) + CFG_W'(LANES - 1)) / CFG_W'(LANES);
  endfunction

  // Byte enables for the final beat of a row; a clamped row always ends on a full beat.
  function automatic logic [STRB_W-1:0] strb_mask(input logic [SIZE_W-1:0] nsize,
                                                  input logic clamped);
    int rem;
    logic [STRB_W-1:0] m;
    rem = int'(nsize) % LANES;
    m   = '1;
    if (!clamped && rem != 0) begin
      for (int i = 0; i < STRB_W; i++) m[i] = (i < rem * ELEM_BYTES);
    end
    return m;
  endfunction

endpackage

// File: rtl/gemm_store_engine_if.sv
// Store-side view of the shared memory interface: ownership request/grant plus write beats.
interface gemm_store_engine_if
  import gemm_store_pkg::*;
();
  // bus_req/bus_gnt arbitrate ownership; a beat transfers on a cycle where wr_valid and
  // wr_ready are both high, and wr_addr/wr_data/wr_strb stay stable while wr_valid waits on wr_ready.
  logic              bus_req;
  logic              bus_gnt;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [BEAT_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;

  modport master (
    output bus_req, wr_valid, wr_addr, wr_data, wr_strb,
    input  bus_gnt, wr_ready
  );

  modport slave (
    input  bus_req, wr_valid, wr_addr, wr_data, wr_strb,
    output bus_gnt, wr_ready
  );
endinterface

// File: rtl/gemm_store_addr_gen.sv
// Row/beat sequencing and beat byte address generation for the store engine.
module gemm_store_addr_gen
  import gemm_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [ADDR_W-1:0] c_stride,
  input  logic [SIZE_W-1:0] rows,
  input  logic [CNT_W-1:0]  beats,
  output logic [BIDX_W-1:0] beat,
  output logic              last_beat,
  output logic              last_row,
  output logic [ADDR_W-1:0] wr_addr
);

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] stride_q;
  logic [SIZE_W-1:0] row;
  logic [SIZE_W-1:0] rows_q;
  logic [CNT_W-1:0]  beats_q;

  // row_base accumulates the stride once per finished row; wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
      stride_q <= '0;
      rows_q   <= '0;
      beats_q  <= '0;
      row      <= '0;
      beat     <= '0;
    end else if (load) begin
      row_base <= c_addr;
      stride_q <= c_stride;
      rows_q   <= rows;
      beats_q  <= beats;
      row      <= '0;
      beat     <= '0;
    end else if (advance) begin
      if (last_beat) begin
        beat     <= '0;
        row      <= row + 1'b1;
        row_base <= row_base + stride_q;
      end else begin
        beat     <= beat + 1'b1;
      end
    end
  end

  assign last_beat = (CNT_W'(beat) == beats_q - CNT_W'(1));
  assign last_row  = (row == rows_q - SIZE_W'(1));
  assign wr_addr   = row_base + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);

endmodule

// File: rtl/gemm_store_engine.sv
// Drains the accumulator column-slice buffers row by row onto the shared write interface.
module gemm_store_engine
  import gemm_store_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SIZE_W-1:0]         msize,
  input  logic [SIZE_W-1:0]         nsize,
  input  logic [ADDR_W-1:0]         c_addr,
  input  logic [ADDR_W-1:0]         c_stride,
  output logic                      busy,
  output logic                      done,
  output logic                      err_clamp,
  input  logic [NUM_BUF-1:0]        buf_valid,
  input  logic [NUM_BUF*BEAT_W-1:0] buf_data,
  output logic [NUM_BUF-1:0]        buf_pop,
  gemm_store_engine_if.master       bus,
  output state_t                    dbg_state
);

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              accept;
  logic              clamp;
  logic              last_beat;
  logic              last_row;
  logic [CFG_W-1:0]  beats_raw;
  logic [CNT_W-1:0]  beats_eff;
  logic [STRB_W-1:0] last_strb_q;
  logic [BIDX_W-1:0] beat;

  assign beats_raw = beats_of(nsize);
  assign clamp     = beats_raw > CFG_W'(NUM_BUF);
  assign beats_eff = clamp ? CNT_W'(NUM_BUF) : CNT_W'(beats_raw);
  assign load      = (state == IDLE) && start;
  assign accept    = bus.wr_valid && bus.wr_ready;
  assign dbg_state = state;

  gemm_store_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (accept),
    .c_addr    (c_addr),
    .c_stride  (c_stride),
    .rows      (msize),
    .beats     (beats_eff),
    .beat      (beat),
    .last_beat (last_beat),
    .last_row  (last_row),
    .wr_addr   (bus.wr_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // err_clamp stays up until the next accepted start re-evaluates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_clamp   <= 1'b0;
      last_strb_q <= '0;
    end else if (load) begin
      err_clamp   <= clamp;
      last_strb_q <= strb_mask(nsize, clamp);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (msize == '0 || nsize == '0) ? FIN : REQ;
      REQ:   if (bus.bus_gnt) state_nxt = ISSUE;
      ISSUE: if (accept && last_beat) state_nxt = last_row ? FIN : GAP;
      GAP:   state_nxt = REQ;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Losing the grant or an empty head buffer only withholds valid; the beat index is kept.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == FIN);
    bus.bus_req  = (state == REQ) || (state == ISSUE);
    bus.wr_valid = (state == ISSUE) && bus.bus_gnt && buf_valid[beat];
  end

  always_comb begin
    buf_pop = '0;
    if (accept) buf_pop[beat] = 1'b1;
  end

  always_comb begin
    bus.wr_data = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (beat == BIDX_W'(i)) bus.wr_data = buf_data[i*BEAT_W +: BEAT_W];
    end
    bus.wr_strb = last_beat ? last_strb_q : '1;
  end

endmodule
